// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared encodings for the multi-cycle multiply/divide unit.
//   - MCycleOp encodings (OP_SMUL, OP_UMUL, OP_SDIV, OP_UDIV)
//   - FSM state type (IDLE, COMPUTING, DONE)
//   - iteration-counter width helper
package mcycle_pkg;

    localparam logic [1:0] OP_SMUL = 2'b00;
    localparam logic [1:0] OP_UMUL = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;
    localparam logic [1:0] OP_UDIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COMPUTING = 2'b01,
        DONE      = 2'b10
    } state_t;

    // Counter only needs to reach WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mcycle_datapath.sv
// mcycle_datapath: operand/accumulator registers for shift-add multiply and
// restoring shift-subtract divide, plus final sign correction.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_load              latch op, operand magnitudes and sign bits
//   i_step              perform one iteration on the accumulator
//   i_finish            write sign-corrected results (same edge as last step)
//   i_op                MCycleOp
//   i_op1, i_op2        operands (sampled on i_load only)
//   o_result1/2         low word / quotient, high word / remainder
module mcycle_datapath
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic [WIDTH-1:0] o_result1,
    output logic [WIDTH-1:0] o_result2
);

    logic               r_is_div;
    logic               r_neg_res;   // product / quotient sign
    logic               r_neg_rem;   // remainder follows the dividend
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_orig1;
    logic [WIDTH-1:0]   r_m;         // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] r_acc;       // {hi, lo}: product / {remainder, dividend-quotient}
    logic [WIDTH-1:0]   r_result1;
    logic [WIDTH-1:0]   r_result2;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_hi_next;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~i_op[0];
    // Magnitude of the most-negative value is itself when read as unsigned.
    assign w_mag1   = (w_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
    assign w_mag2   = (w_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Shift-add: multiplier sits in lo and is consumed LSB first.
    assign w_sum      = {1'b0, w_hi} + {1'b0, r_m};
    assign w_hi_next  = w_lo[0] ? w_sum : {1'b0, w_hi};
    assign w_mul_next = {w_hi_next, w_lo[WIDTH-1:1]};

    // Restoring divide: extra bit on w_diff catches a negative trial result.
    assign w_shift    = {w_hi, w_lo[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_m};
    assign w_div_next = w_diff[WIDTH+1]
                      ? {w_shift[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0],  w_lo[WIDTH-2:0], 1'b1};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod = r_neg_res ? -w_acc_next : w_acc_next;
    assign w_quo  = r_neg_res ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_orig1    <= '0;
            r_m        <= '0;
            r_acc      <= '0;
            r_result1  <= '0;
            r_result2  <= '0;
        end else begin
            if (i_load) begin
                r_is_div   <= i_op[1];
                r_neg_res  <= w_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                r_neg_rem  <= w_signed & i_op1[WIDTH-1];
                r_div_zero <= (i_op2 == '0);
                r_orig1    <= i_op1;
                r_m        <= i_op[1] ? w_mag2 : w_mag1;
                r_acc      <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag1 : w_mag2)};
            end else if (i_step) begin
                r_acc <= w_acc_next;
            end
            if (i_finish) begin
                if (!r_is_div) begin
                    r_result1 <= w_prod[WIDTH-1:0];
                    r_result2 <= w_prod[2*WIDTH-1:WIDTH];
                end else if (r_div_zero) begin
                    r_result1 <= '1;
                    r_result2 <= r_orig1;
                end else begin
                    r_result1 <= w_quo;
                    r_result2 <= w_rem;
                end
            end
        end
    end

    assign o_result1 = r_result1;
    assign o_result2 = r_result2;

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle multiply/divide responder for the execute stage.
// Ports:
//   CLK, RESET          clock, async active-high reset
//   Start               start strobe (accepted only in IDLE or DONE)
//   MCycleOp            00 smul, 01 umul, 10 sdiv, 11 udiv
//   Operand1, Operand2  multiplicand/dividend, multiplier/divisor
//   Result1, Result2    product low/high, or quotient/remainder
//   Busy                stall request (start cycle plus WIDTH compute cycles)
//   Done                one-cycle pulse when results are valid
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_t          r_state;
    state_t          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic            w_load;
    logic            w_step;
    logic            w_finish;
    logic            w_busy;
    logic            w_done;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                w_done = (r_state == DONE);
                if (Start) begin
                    w_load       = 1'b1;
                    w_busy       = 1'b1;
                    w_state_next = COMPUTING;
                end else begin
                    w_state_next = IDLE;
                end
            end
            COMPUTING: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Start is combinational into Busy, so gate it while reset is held.
    assign Busy = w_busy & ~RESET;
    assign Done = w_done;

    mcycle_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_finish  (w_finish),
        .i_op      (MCycleOp),
        .i_op1     (Operand1),
        .i_op2     (Operand2),
        .o_result1 (Result1),
        .o_result2 (Result2)
    );

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    always #5 CLK = ~CLK;

    mcycle_unit #(
        .WIDTH(W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    // Drives Start in cycle 0, returns Busy seen in that cycle; leaves just after
    // the accepting edge with junk on the don't-care inputs.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic busy0);
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        #1 busy0 = Busy;
        @(posedge CLK);
        #1;
        Start = 1'b0; MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
    endtask

    // Bounded wait for Done; cyc is the cycle index relative to the start cycle.
    task automatic wait_done(output int cyc, output bit busy_ok);
        busy_ok = 1'b1;
        cyc     = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (Done) begin
                cyc = c;
                return;
            end
            if (Busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 5; Operand2 = 6;
        #3;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
        total++; if (Result1 !== '0) begin bad++; $display("FAIL reset_r1 got=%h want=0", Result1); end
        total++; if (Result2 !== '0) begin bad++; $display("FAIL reset_r2 got=%h want=0", Result2); end
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b want=0", Done); end
    endtask

    task automatic test_mul();
        vec_t v[4];
        logic b0; int cyc; bit bok;
        v[0] = '{OP_SMUL, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF};
        v[1] = '{OP_UMUL, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFE, 32'h00000001};
        v[2] = '{OP_SMUL, 32'hFFFFFFFC,  32'hFFFFFFFB, 32'd20,       32'd0};
        v[3] = '{OP_SMUL, 32'h80000000,  32'h80000000, 32'h00000000, 32'h40000000};
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b, b0);
            wait_done(cyc, bok);
            total++; if (b0 !== 1'b1) begin bad++; $display("FAIL mul%0d_busy0 got=%b want=1", i, b0); end
            total++; if (!bok) begin bad++; $display("FAIL mul%0d_busy_hold got=0 want=1", i); end
            total++; if (cyc != 33) begin bad++; $display("FAIL mul%0d_latency got=%0d want=33", i, cyc); end
            total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mul%0d_busy_done got=%b want=0", i, Busy); end
            total++; if (Result1 !== v[i].e1) begin bad++; $display("FAIL mul%0d_r1 got=%h want=%h", i, Result1, v[i].e1); end
            total++; if (Result2 !== v[i].e2) begin bad++; $display("FAIL mul%0d_r2 got=%h want=%h", i, Result2, v[i].e2); end
        end
    endtask

    task automatic test_div();
        vec_t v[5];
        logic b0; int cyc; bit bok;
        v[0] = '{OP_SDIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        v[1] = '{OP_UDIV, 32'd100,      32'd7,        32'd14,       32'd2};
        v[2] = '{OP_SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        v[3] = '{OP_SDIV, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
        v[4] = '{OP_UDIV, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b, b0);
            wait_done(cyc, bok);
            total++; if (!bok || b0 !== 1'b1) begin bad++; $display("FAIL div%0d_busy got=%b/%b want=1/1", i, b0, bok); end
            total++; if (cyc != 33) begin bad++; $display("FAIL div%0d_latency got=%0d want=33", i, cyc); end
            total++; if (Result1 !== v[i].e1) begin bad++; $display("FAIL div%0d_r1 got=%h want=%h", i, Result1, v[i].e1); end
            total++; if (Result2 !== v[i].e2) begin bad++; $display("FAIL div%0d_r2 got=%h want=%h", i, Result2, v[i].e2); end
        end
    endtask

    task automatic test_div_zero();
        vec_t v[2];
        logic b0; int cyc; bit bok;
        v[0] = '{OP_UDIV, 32'd100,      32'd0, 32'hFFFFFFFF, 32'd100};
        v[1] = '{OP_SDIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        foreach (v[i]) begin
            launch(v[i].op, v[i].a, v[i].b, b0);
            wait_done(cyc, bok);
            total++; if (cyc != 33) begin bad++; $display("FAIL dz%0d_latency got=%0d want=33", i, cyc); end
            total++; if (Result1 !== v[i].e1) begin bad++; $display("FAIL dz%0d_r1 got=%h want=%h", i, Result1, v[i].e1); end
            total++; if (Result2 !== v[i].e2) begin bad++; $display("FAIL dz%0d_r2 got=%h want=%h", i, Result2, v[i].e2); end
        end
    endtask

    task automatic test_back_to_back();
        logic b0; int cyc; bit bok; int first; int extra;
        launch(OP_UMUL, 32'd6, 32'd7, b0);
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (Done) begin
                first = c;
                break;
            end
            if (c == 10) begin
                // Stray Start while computing must be ignored.
                Start = 1'b1; MCycleOp = OP_UDIV; Operand1 = 32'd1; Operand2 = 32'd0;
                @(posedge CLK);
                #1 Start = 1'b0;
            end
        end
        total++; if (first != 33) begin bad++; $display("FAIL ign_latency got=%0d want=33", first); end
        total++; if (Result1 !== 32'd42) begin bad++; $display("FAIL ign_r1 got=%h want=%h", Result1, 32'd42); end
        total++; if (Result2 !== 32'd0) begin bad++; $display("FAIL ign_r2 got=%h want=0", Result2); end
        // New Start in the Done cycle.
        Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 32'd3; Operand2 = 32'd5;
        #1;
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL b2b_busy0 got=%b want=1", Busy); end
        @(posedge CLK);
        #1 Start = 1'b0;
        wait_done(cyc, bok);
        total++; if (!bok) begin bad++; $display("FAIL b2b_busy_hold got=0 want=1"); end
        total++; if (cyc != 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", cyc); end
        total++; if (Result1 !== 32'd15) begin bad++; $display("FAIL b2b_r1 got=%h want=%h", Result1, 32'd15); end
        total++; if (Result2 !== 32'd0) begin bad++; $display("FAIL b2b_r2 got=%h want=0", Result2); end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (Done) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_no_extra_done got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic b0; int cyc; bit bok; int dones;
        launch(OP_UDIV, 32'd100, 32'd7, b0);
        for (int c = 1; c <= 12; c++) @(negedge CLK);
        RESET = 1'b1;
        #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", Busy); end
        total++; if (Result1 !== '0) begin bad++; $display("FAIL rmid_r1 got=%h want=0", Result1); end
        total++; if (Result2 !== '0) begin bad++; $display("FAIL rmid_r2 got=%h want=0", Result2); end
        dones = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            if (Done) dones++;
        end
        RESET = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (Done || Busy) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", dones); end
        launch(OP_SDIV, 32'd100, 32'hFFFFFFF9, b0);
        wait_done(cyc, bok);
        total++; if (cyc != 33) begin bad++; $display("FAIL rpost_latency got=%0d want=33", cyc); end
        total++; if (Result1 !== 32'hFFFFFFF2) begin bad++; $display("FAIL rpost_r1 got=%h want=%h", Result1, 32'hFFFFFFF2); end
        total++; if (Result2 !== 32'd2) begin bad++; $display("FAIL rpost_r2 got=%h want=%h", Result2, 32'd2); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
